// File: rtl/prog_delay_line.sv
// rtl/prog_delay_line.sv - multi-channel programmable delay line with runtime tap
//
// Purpose: NCH signed channels share one DEPTH-sample shift storage that
// advances on din_valid. A loadable tap selects the delay: tap t gives a
// (t+1)-sample delay. Out-of-range taps clamp to DEPTH-1 and set a sticky error.
// Optional feature macro: PROG_DELAY_PRIME_EN. When it is defined, dout_valid is
// held low until the tapped slot holds a sample written since reset/flush.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous reset, active low
//   din_valid  sample strobe; storage advances only when high
//   din        NCH*WIDTH samples, channel c at [c*WIDTH +: WIDTH]
//   flush      single-cycle clear of fill state (no shift that cycle)
//   tap_load   single-cycle strobe capturing tap_in
//   tap_in     requested delay tap
//   dout       delayed samples, registered
//   dout_valid dout updated this cycle (and primed when the macro is defined)
//   tap_cur    tap in effect
//   tap_err    sticky flag: a tap_in >= DEPTH was loaded

module prog_delay_line #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 32,
   parameter int NCH   = 2,
   parameter int TAP_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   din_valid,
   input  logic [NCH*WIDTH-1:0]   din,
   input  logic                   flush,
   input  logic                   tap_load,
   input  logic [TAP_W-1:0]       tap_in,
   output logic [NCH*WIDTH-1:0]   dout,
   output logic                   dout_valid,
   output logic [TAP_W-1:0]       tap_cur,
   output logic                   tap_err
);

   localparam int DW = NCH * WIDTH;
   localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(DEPTH - 1);

   // Storage has no reset so it maps onto shift-register primitives.
   logic [DW-1:0] line [DEPTH];
   logic [DW-1:0] rd_word;
   logic          shift_en;
   logic          tap_oob;

   assign shift_en = rst_n && din_valid && !flush;
   assign rd_word  = line[tap_cur];
   // Widen before comparing so the check still works when DEPTH is not a power of two.
   assign tap_oob  = 32'(tap_in) >= 32'(DEPTH);

   always_ff @(posedge clk) begin
      if (shift_en) begin
         line[0] <= din;
         for (int n = 1; n < DEPTH; n++) begin
            line[n] <= line[n-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tap_cur <= '0;
         tap_err <= 1'b0;
      end else if (tap_load) begin
         if (tap_oob) begin
            tap_cur <= TAP_MAX;
            tap_err <= 1'b1;
         end else begin
            tap_cur <= tap_in;
         end
      end
   end

`ifdef PROG_DELAY_PRIME_EN
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

   logic [FILL_W-1:0] fill_cnt;
   logic              primed;

   // The read slot line[tap_cur] is real once more than tap_cur samples have
   // entered since reset/flush; the comparison uses the pre-shift count.
   assign primed = 32'(fill_cnt) > 32'(tap_cur);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_cnt   <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (flush) begin
         fill_cnt   <= '0;
         dout_valid <= 1'b0;
      end else if (din_valid) begin
         if (fill_cnt != FILL_MAX) begin
            fill_cnt <= fill_cnt + FILL_W'(1);
         end
         if (primed) begin
            dout       <= rd_word;
            dout_valid <= 1'b1;
         end else begin
            dout       <= '0;
            dout_valid <= 1'b0;
         end
      end else begin
         dout_valid <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (flush) begin
         dout_valid <= 1'b0;
      end else if (din_valid) begin
         dout       <= rd_word;
         dout_valid <= 1'b1;
      end else begin
         dout_valid <= 1'b0;
      end
   end
`endif

endmodule
